// File: rtl/digit_frame_loader_pkg.sv
// Shared types and constants for the digit frame loader.
package digit_frame_loader_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    COMMIT = 1'b1
  } state_t;

  localparam int NDIG        = 4;
  localparam int IDX_W       = 2;
  localparam int DEF_TIMEOUT = 1000;

endpackage

// File: rtl/digit_frame_loader_if.sv
// Producer-to-loader digit stream: valid/ready handshake plus abort.
interface digit_frame_loader_if #(
  parameter int W = 4
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         abort;

  modport master (
    output in_valid,
    output in_data,
    output abort,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  abort,
    output in_ready
  );

endinterface

// File: rtl/digit_frame_loader.sv
// Digit frame loader: collects four digits into a shadow bank and commits
// them atomically to the live display outputs so the display never tears.
// Optional feature: define DIGIT_FRAME_LOADER_TIMEOUT_EN to discard partial
// frames after TIMEOUT idle clocks and raise the sticky err flag.
module digit_frame_loader
  import digit_frame_loader_pkg::*;
#(
  parameter int W       = 4,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  digit_frame_loader_if.slave  bus,
  output logic [W-1:0]         D0,
  output logic [W-1:0]         D1,
  output logic [W-1:0]         D2,
  output logic [W-1:0]         D3,
  output logic                 frame_done,
  output logic [IDX_W-1:0]     wr_idx,
  output logic                 err
);

  if (TIMEOUT < 2) begin : g_timeout_check
    $error("digit_frame_loader: TIMEOUT must be at least 2");
  end

  state_t           r_state;
  logic [IDX_W-1:0] r_wr_idx;
  logic             r_in_ready;
  logic             r_frame_done;
  logic [W-1:0]     r_shadow [NDIG];
  logic [W-1:0]     r_live   [NDIG];

  logic             w_timeout;
  logic             w_abort;

  // A timeout expiry is handled exactly like a producer abort.
  assign w_abort = bus.abort | w_timeout;

`ifdef DIGIT_FRAME_LOADER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] r_idle_cnt;
  logic             r_err;
  logic             w_xfer;

  assign w_xfer    = (r_state == FILL) & bus.in_valid & ~w_abort;
  assign w_timeout = (r_state == FILL) && (r_wr_idx != '0) &&
                     (r_idle_cnt == CNT_W'(TIMEOUT - 1));

  // Idle counter: runs only while a partial frame sits in the shadow bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if ((r_state != FILL) || (r_wr_idx == '0) || w_xfer ||
                 bus.abort || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + CNT_W'(1);
    end
  end

  // Sticky error: set by an expiry, cleared when the next frame commits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if (r_state == COMMIT) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // Frame FSM: fill the shadow bank in order, then copy it to the live bank
  // in a single commit cycle during which no new digit is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= FILL;
      r_wr_idx     <= '0;
      r_in_ready   <= 1'b1;
      r_frame_done <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        r_shadow[i] <= '0;
        r_live[i]   <= '0;
      end
    end else begin
      case (r_state)
        FILL: begin
          r_frame_done <= 1'b0;
          if (w_abort) begin
            r_wr_idx <= '0;
          end else if (bus.in_valid) begin
            r_shadow[r_wr_idx] <= bus.in_data;
            r_wr_idx           <= r_wr_idx + IDX_W'(1);
            if (r_wr_idx == IDX_W'(NDIG - 1)) begin
              r_state      <= COMMIT;
              r_in_ready   <= 1'b0;
              r_frame_done <= 1'b1;
            end
          end
        end
        COMMIT: begin
          for (int i = 0; i < NDIG; i++) begin
            r_live[i] <= r_shadow[i];
          end
          r_frame_done <= 1'b0;
          r_in_ready   <= 1'b1;
          r_state      <= FILL;
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign frame_done   = r_frame_done;
  assign wr_idx       = r_wr_idx;
  assign D0           = r_live[0];
  assign D1           = r_live[1];
  assign D2           = r_live[2];
  assign D3           = r_live[3];

endmodule

// File: tb/tb_digit_frame_loader.sv
// Bench for digit_frame_loader: directed scenarios plus random traffic,
// checked against a queue-based frame model.
module tb_digit_frame_loader;

  localparam int TO = 8;
`ifdef DIGIT_FRAME_LOADER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] D0, D1, D2, D3;
  logic       frame_done;
  logic [1:0] wr_idx;
  logic       err;

  always #5 clk = ~clk;

  digit_frame_loader_if #(.W(4)) bus ();

  digit_frame_loader #(.W(4), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .D0         (D0),
    .D1         (D1),
    .D2         (D2),
    .D3         (D3),
    .frame_done (frame_done),
    .wr_idx     (wr_idx),
    .err        (err)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: partial frame as a queue, completed frame waits one
  // cycle (commit) before it becomes the live bank.
  logic [3:0] m_q[$];
  logic [3:0] m_live  [4];
  logic [3:0] m_frame [4];
  bit         m_commit;
  bit         m_err;
  int         m_idle;
  bit         m_acc;

  function automatic void model_edge(input bit r, input bit v,
                                     input logic [3:0] d, input bit ab);
    bit to;
    m_acc = 1'b0;
    if (!r) begin
      m_q.delete();
      for (int i = 0; i < 4; i++) m_live[i] = 4'h0;
      m_commit = 1'b0;
      m_err    = 1'b0;
      m_idle   = 0;
    end else if (m_commit) begin
      for (int i = 0; i < 4; i++) m_live[i] = m_frame[i];
      m_commit = 1'b0;
      m_err    = 1'b0;
    end else begin
      to = TO_EN && (m_q.size() != 0) && (m_idle == TO - 1);
      if (ab || to) begin
        m_q.delete();
        m_idle = 0;
        if (to) m_err = 1'b1;
      end else if (v) begin
        m_q.push_back(d);
        m_idle = 0;
        m_acc  = 1'b1;
        if (m_q.size() == 4) begin
          for (int i = 0; i < 4; i++) m_frame[i] = m_q[i];
          m_q.delete();
          m_commit = 1'b1;
        end
      end else if (m_q.size() != 0) begin
        m_idle++;
      end
    end
  endfunction

  function automatic logic [15:0] exp_d();
    return {m_live[3], m_live[2], m_live[1], m_live[0]};
  endfunction

  task automatic step(input bit r, input bit v, input logic [3:0] d, input bit ab);
    rst_n        = r;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.abort    = ab;
    @(posedge clk);
    model_edge(r, v, d, ab);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 4'h0, 1'b0);
    step(1'b0, 1'b1, 4'hF, 1'b0);
    n_total++;
    if ({D3, D2, D1, D0, wr_idx, frame_done, err, bus.in_ready} !== {16'h0, 2'd0, 1'b0, 1'b0, 1'b1}) begin
      $display("FAIL reset_state: got D=%h idx=%0d fd=%b err=%b rdy=%b required D=0000 idx=0 fd=0 err=0 rdy=1",
               {D3, D2, D1, D0}, wr_idx, frame_done, err, bus.in_ready);
    end else n_pass++;
    step(1'b1, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_basic();
    logic [3:0] digs [4];
    digs = '{4'h1, 4'h2, 4'h3, 4'h4};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, digs[i], 1'b0);
      n_total++;
      if (wr_idx !== 2'((i + 1) % 4) || wr_idx !== 2'(m_q.size())) begin
        $display("FAIL basic_wr_idx: got %0d required %0d", wr_idx, (i + 1) % 4);
      end else n_pass++;
    end
    n_total++;
    if (frame_done !== 1'b1 || bus.in_ready !== 1'b0 || {D3, D2, D1, D0} !== 16'h0) begin
      $display("FAIL basic_commit_cycle: got fd=%b rdy=%b D=%h required fd=1 rdy=0 D=0000",
               frame_done, bus.in_ready, {D3, D2, D1, D0});
    end else n_pass++;
    step(1'b1, 1'b0, 4'h0, 1'b0);
    n_total++;
    if ({D3, D2, D1, D0} !== 16'h4321 || {D3, D2, D1, D0} !== exp_d() ||
        frame_done !== 1'b0 || bus.in_ready !== 1'b1) begin
      $display("FAIL basic_live: got D=%h fd=%b rdy=%b required D=4321 fd=0 rdy=1",
               {D3, D2, D1, D0}, frame_done, bus.in_ready);
    end else n_pass++;
  endtask

  task automatic test_abort();
    logic [3:0] digs [4];
    digs = '{4'h5, 4'h6, 4'h7, 4'h8};
    step(1'b1, 1'b1, 4'hA, 1'b0);
    step(1'b1, 1'b1, 4'hB, 1'b0);
    step(1'b1, 1'b1, 4'hC, 1'b1);
    n_total++;
    if (wr_idx !== 2'd0 || {D3, D2, D1, D0} !== 16'h4321) begin
      $display("FAIL abort_restart: got idx=%0d D=%h required idx=0 D=4321", wr_idx, {D3, D2, D1, D0});
    end else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, (i < 4), (i < 4) ? digs[i] : 4'h0, 1'b0);
      n_total++;
      if ({D3, D2, D1, D0} !== exp_d()) begin
        $display("FAIL abort_live_cycle%0d: got D=%h required %h", i, {D3, D2, D1, D0}, exp_d());
      end else n_pass++;
    end
    n_total++;
    if ({D3, D2, D1, D0} !== 16'h8765) begin
      $display("FAIL abort_final: got D=%h required 8765", {D3, D2, D1, D0});
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] digs [8];
    int k = 0;
    int cyc = 0;
    int fd_cyc[$];
    digs = '{4'h9, 4'h9, 4'h9, 4'h9, 4'h1, 4'h2, 4'h3, 4'h4};
    while (k < 8 && cyc < 40) begin
      step(1'b1, 1'b1, digs[k], 1'b0);
      cyc++;
      if (m_acc) k++;
      if (frame_done) fd_cyc.push_back(cyc);
      n_total++;
      if (wr_idx !== 2'(m_q.size()) || bus.in_ready !== !m_commit) begin
        $display("FAIL b2b_handshake: got idx=%0d rdy=%b required idx=%0d rdy=%b",
                 wr_idx, bus.in_ready, m_q.size(), !m_commit);
      end else n_pass++;
    end
    n_total++;
    if (k != 8) begin
      $display("FAIL b2b_timeout: got %0d digits accepted required 8", k);
    end else n_pass++;
    step(1'b1, 1'b0, 4'h0, 1'b0);
    if (frame_done) fd_cyc.push_back(cyc + 1);
    n_total++;
    if (fd_cyc.size() != 2 || fd_cyc[1] - fd_cyc[0] != 5) begin
      $display("FAIL b2b_frame_done: got %0d pulses (spacing %0d) required 2 pulses spacing 5",
               fd_cyc.size(), (fd_cyc.size() == 2) ? fd_cyc[1] - fd_cyc[0] : -1);
    end else n_pass++;
    n_total++;
    if ({D3, D2, D1, D0} !== 16'h4321) begin
      $display("FAIL b2b_live: got D=%h required 4321", {D3, D2, D1, D0});
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'(i + 7), 1'b0);
    step(1'b0, 1'b1, 4'hE, 1'b0);
    n_total++;
    if ({D3, D2, D1, D0} !== 16'h0 || wr_idx !== 2'd0 || frame_done !== 1'b0) begin
      $display("FAIL reset_mid: got D=%h idx=%0d fd=%b required D=0000 idx=0 fd=0",
               {D3, D2, D1, D0}, wr_idx, frame_done);
    end else n_pass++;
    step(1'b1, 1'b0, 4'h0, 1'b0);
    n_total++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL reset_mid_ready: got %b required 1", bus.in_ready);
    end else n_pass++;
  endtask

`ifdef DIGIT_FRAME_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    step(1'b1, 1'b1, 4'h6, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 4'h0, 1'b0);
    n_total++;
    if (wr_idx !== 2'd1 || err !== 1'b0) begin
      $display("FAIL timeout_early: got idx=%0d err=%b required idx=1 err=0", wr_idx, err);
    end else n_pass++;
    step(1'b1, 1'b0, 4'h0, 1'b0);
    n_total++;
    if (wr_idx !== 2'd0 || err !== 1'b1 || {D3, D2, D1, D0} !== 16'h0 || err !== m_err) begin
      $display("FAIL timeout_expire: got idx=%0d err=%b D=%h required idx=0 err=1 D=0000",
               wr_idx, err, {D3, D2, D1, D0});
    end else n_pass++;
    for (int i = 0; i < 5; i++) step(1'b1, (i < 4), 4'(i + 1), 1'b0);
    n_total++;
    if (err !== 1'b0 || {D3, D2, D1, D0} !== 16'h4321) begin
      $display("FAIL timeout_clear: got err=%b D=%h required err=0 D=4321", err, {D3, D2, D1, D0});
    end else n_pass++;
  endtask
`endif

  task automatic test_random();
    bit r, v, ab;
    logic [3:0] d;
    int bad = 0;
    for (int c = 0; c < 400; c++) begin
      r  = ($urandom_range(0, 63) != 0);
      v  = ($urandom_range(0, 3) != 0);
      ab = ($urandom_range(0, 15) == 0);
      d  = 4'($urandom);
      if (c % 50 < 12) v = 1'b0;
      step(r, v, d, ab);
      n_total++;
      if ({D3, D2, D1, D0} !== exp_d() || wr_idx !== 2'(m_q.size()) ||
          frame_done !== m_commit || bus.in_ready !== !m_commit || err !== m_err) begin
        if (bad < 10) begin
          $display("FAIL random_cycle%0d: got D=%h idx=%0d fd=%b rdy=%b err=%b required D=%h idx=%0d fd=%b rdy=%b err=%b",
                   c, {D3, D2, D1, D0}, wr_idx, frame_done, bus.in_ready, err,
                   exp_d(), m_q.size(), m_commit, !m_commit, m_err);
        end
        bad++;
      end else n_pass++;
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
    bus.abort    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_live[i]  = 4'h0;
      m_frame[i] = 4'h0;
    end
    m_commit = 1'b0;
    m_err    = 1'b0;
    m_idle   = 0;
    m_acc    = 1'b0;
    test_reset();
    test_basic();
    test_abort();
    test_back_to_back();
    test_reset_mid();
`ifdef DIGIT_FRAME_LOADER_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
